// File: rtl/spy_pkg.sv
// spy_pkg
// Shared definitions for the spy capture memory controllers (capture-side
// writer and read-side readout). Holds the memory geometry and the readout
// state encoding.
package spy_pkg;

  localparam int SPY_AW = 10;  // spy memory address width (1024 words)
  localparam int SPY_DW = 16;  // spy memory data width

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_READ  = 2'd1,
    RD_DRAIN = 2'd2
  } rd_state_e;

endpackage

// File: rtl/spy_readout_fifo.sv
// spy_readout_fifo
// Small synchronous show-ahead FIFO used as the readout output buffer.
// The head word is visible combinationally whenever the FIFO is not empty.
//
// Ports:
//   clk, reset    system clock, synchronous active-high reset
//   push_i        write data_i into the tail this edge
//   data_i        word to push
//   pop_i         drop the head word this edge (ignored when empty)
//   head_o        current head word (valid when !empty_o)
//   count_o       number of stored words
//   full_o        count_o == DEPTH
//   empty_o       count_o == 0
module spy_readout_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 16,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic [DW-1:0] data_i,
  input  logic          pop_i,
  output logic [DW-1:0] head_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_pop;

  // Pointers wrap at DEPTH so non-power-of-two depths work.
  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= bump(wr_ptr_q);
      if (do_pop) rd_ptr_q <= bump(rd_ptr_q);
      unique case ({push_i, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // A push into a full FIFO with no simultaneous pop would lose data.
  assert property (@(posedge clk) disable iff (reset) !(push_i && !do_pop && full_o));

endmodule

// File: rtl/spy_readout.sv
// spy_readout
// Read-side controller for the spy capture memory. A start request reads a
// window of rd_count words beginning at rd_base (wrapping modulo 2^AW) and
// streams them out on a valid/ready interface, marking the final word.
// Reads are only issued while a credit is free, so the output FIFO absorbs
// any backpressure without overflowing.
//
// Ports:
//   clk, reset         system clock, synchronous active-high reset
//   start_i            single-cycle readout request
//   rd_base_i          first window address, sampled on accepted start
//   rd_count_i         window length 0..2^AW, sampled on accepted start
//   wr_busy_i          capture side is writing; blocks start
//   rden_o, raddr_o    memory read port request (registered)
//   rdata_i            memory read data, valid RD_LAT cycles after rden_o
//   out_data_o         streamed word (0 when nothing is valid)
//   out_valid_o        out_data_o valid
//   out_ready_i        sink accepts when out_valid_o && out_ready_i
//   out_last_o         final word of the window
//   busy_o             window in progress
//   done_o             one-cycle pulse after the last word is accepted
//   start_err_o        one-cycle pulse when a start is rejected
module spy_readout
  import spy_pkg::*;
#(
  parameter int AW         = SPY_AW,
  parameter int DW         = SPY_DW,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = RD_LAT + 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start_i,
  input  logic [AW-1:0] rd_base_i,
  input  logic [AW:0]   rd_count_i,
  input  logic          wr_busy_i,
  output logic          rden_o,
  output logic [AW-1:0] raddr_o,
  input  logic [DW-1:0] rdata_i,
  output logic [DW-1:0] out_data_o,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic          out_last_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          start_err_o
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  rd_state_e     state_q;
  logic          rden_q;
  logic [AW-1:0] raddr_q;
  logic [AW-1:0] next_addr_q;
  logic [AW:0]   issue_left_q;
  logic [AW:0]   cnt_q;
  logic [AW:0]   pop_cnt_q;
  logic [CW-1:0] occ_q;
  logic [RD_LAT-1:0] lat_q;
  logic          busy_q;
  logic          done_q;
  logic          start_err_q;

  logic          push;
  logic          pop;
  logic          issue;
  logic          credit_ok;
  logic          accept;
  logic [CW-1:0] occ_after_pop;
  logic [DW-1:0] fifo_head;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;

  spy_readout_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    (DW),
    .CW    (CW)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .data_i  (rdata_i),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign out_valid_o = !fifo_empty;
  assign out_data_o  = fifo_empty ? '0 : fifo_head;
  assign out_last_o  = out_valid_o && ((pop_cnt_q + (AW+1)'(1)) == cnt_q);
  assign pop         = out_valid_o && out_ready_i;
  assign push        = lat_q[RD_LAT-1];

  // occ_q counts reads already requested (including the one on rden_o this
  // cycle) whose word has not yet left the FIFO. Because rden is registered,
  // the decision for the next cycle uses the occupancy after this edge's pop,
  // which guarantees a FIFO slot for every read in flight.
  assign occ_after_pop = occ_q - CW'(pop);
  assign credit_ok     = occ_after_pop < CW'(FIFO_DEPTH);
  assign accept        = (state_q == RD_IDLE) && start_i && !wr_busy_i;

  always_comb begin
    issue = 1'b0;
    unique case (state_q)
      RD_IDLE: issue = accept && (rd_count_i != '0);
      RD_READ: issue = credit_ok;
      default: issue = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RD_IDLE;
      rden_q       <= 1'b0;
      raddr_q      <= '0;
      next_addr_q  <= '0;
      issue_left_q <= '0;
      cnt_q        <= '0;
      pop_cnt_q    <= '0;
      occ_q        <= '0;
      lat_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      start_err_q  <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      start_err_q <= 1'b0;
      rden_q      <= issue;
      occ_q       <= occ_after_pop + CW'(issue);
      // Read-latency tracker: a bit enters with rden and reaches the top
      // exactly in the cycle its rdata is valid.
      lat_q[0]    <= rden_q;
      for (int i = 1; i < RD_LAT; i++) lat_q[i] <= lat_q[i-1];
      if (pop) pop_cnt_q <= pop_cnt_q + (AW+1)'(1);

      unique case (state_q)
        RD_IDLE: begin
          if (start_i && wr_busy_i) begin
            start_err_q <= 1'b1;
          end else if (start_i) begin
            cnt_q     <= rd_count_i;
            pop_cnt_q <= '0;
            if (rd_count_i == '0) begin
              done_q <= 1'b1;
            end else begin
              busy_q       <= 1'b1;
              raddr_q      <= rd_base_i;
              next_addr_q  <= rd_base_i + AW'(1);
              issue_left_q <= rd_count_i - (AW+1)'(1);
              state_q      <= (rd_count_i == (AW+1)'(1)) ? RD_DRAIN : RD_READ;
            end
          end
        end
        RD_READ: begin
          if (start_i) start_err_q <= 1'b1;
          if (issue) begin
            raddr_q      <= next_addr_q;
            next_addr_q  <= next_addr_q + AW'(1);
            issue_left_q <= issue_left_q - (AW+1)'(1);
            if (issue_left_q == (AW+1)'(1)) state_q <= RD_DRAIN;
          end
        end
        RD_DRAIN: begin
          if (start_i) start_err_q <= 1'b1;
          if (pop && out_last_o) begin
            state_q <= RD_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= RD_IDLE;
      endcase
    end
  end

  assign rden_o      = rden_q;
  assign raddr_o     = raddr_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign start_err_o = start_err_q;

  // The FIFO can never hold more words than reads that were requested.
  assert property (@(posedge clk) disable iff (reset) fifo_count <= occ_q);
  assert property (@(posedge clk) disable iff (reset) !(push && !pop && fifo_full));

endmodule

// File: tb/tb_spy_readout.sv
// tb_spy_readout
// Self-checking bench for spy_readout. A memory model answers reads after
// RD_LAT cycles; the reference model describes a window purely as the word
// sequence mem[(base + i) mod 1024], i = 0..count-1, and checks addresses,
// data, last marking, credit limit, stall stability and done timing.
module tb_spy_readout;

  localparam int AW         = 10;
  localparam int DW         = 16;
  localparam int RD_LAT     = 2;
  localparam int FIFO_DEPTH = RD_LAT + 2;
  localparam int NWORDS     = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start_i = 1'b0;
  logic [AW-1:0] rd_base_i = '0;
  logic [AW:0]   rd_count_i = '0;
  logic          wr_busy_i = 1'b0;
  logic          rden_o;
  logic [AW-1:0] raddr_o;
  logic [DW-1:0] rdata_i;
  logic [DW-1:0] out_data_o;
  logic          out_valid_o;
  logic          out_ready_i = 1'b1;
  logic          out_last_o;
  logic          busy_o;
  logic          done_o;
  logic          start_err_o;

  logic [DW-1:0] mem [NWORDS];
  logic [AW-1:0] aPipe [RD_LAT];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model state for the current window
  int winBase = 0;
  int winCount = 0;
  int issueCnt = 0;
  int popCnt = 0;
  int doneCount = 0;
  int acceptCyc = 0;
  int firstRdenCyc = 0;
  int lastRdenCyc = 0;
  int firstValidCyc = 0;
  int lastHsCyc = 0;
  int doneCyc = 0;
  bit prevStall = 1'b0;
  logic [DW-1:0] prevData = '0;
  bit readyRandom = 1'b0;

  spy_readout #(
    .AW         (AW),
    .DW         (DW),
    .RD_LAT     (RD_LAT),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start_i     (start_i),
    .rd_base_i   (rd_base_i),
    .rd_count_i  (rd_count_i),
    .wr_busy_i   (wr_busy_i),
    .rden_o      (rden_o),
    .raddr_o     (raddr_o),
    .rdata_i     (rdata_i),
    .out_data_o  (out_data_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_last_o  (out_last_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .start_err_o (start_err_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory read port: data for the address of cycle C appears in C+RD_LAT.
  always @(posedge clk) begin
    aPipe[0] <= raddr_o;
    for (int i = 1; i < RD_LAT; i++) aPipe[i] <= aPipe[i-1];
  end
  assign rdata_i = mem[aPipe[RD_LAT-1]];

  always @(posedge clk) begin
    #1;
    out_ready_i = readyRandom ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Monitor: compares every read request and every accepted word with the model.
  always @(negedge clk) begin
    if (reset) begin
      prevStall = 1'b0;
    end else begin
      if (rden_o) begin
        checkOutput("read_in_window", 32'(issueCnt < winCount), 32'd1);
        checkOutput("raddr", 32'(raddr_o), 32'((winBase + issueCnt) % NWORDS));
        if (issueCnt == 0) firstRdenCyc = cyc;
        lastRdenCyc = cyc;
        issueCnt++;
        checkOutput("credit_limit", 32'((issueCnt - popCnt) <= FIFO_DEPTH), 32'd1);
      end
      if (prevStall) begin
        checkOutput("stall_valid", 32'(out_valid_o), 32'd1);
        checkOutput("stall_data", 32'(out_data_o), 32'(prevData));
      end
      if (out_valid_o) begin
        checkOutput("valid_in_window", 32'(popCnt < winCount), 32'd1);
        if (popCnt == 0) firstValidCyc = cyc;
        if (out_ready_i) begin
          checkOutput("out_data", 32'(out_data_o), 32'(mem[(winBase + popCnt) % NWORDS]));
          checkOutput("out_last", 32'(out_last_o), 32'(popCnt == winCount - 1));
          if (out_last_o) lastHsCyc = cyc;
          popCnt++;
        end
      end
      prevStall = out_valid_o && !out_ready_i;
      prevData  = out_data_o;
      if (done_o) begin
        doneCount++;
        doneCyc = cyc;
      end
    end
  end

  // Pulse start for one cycle; returns in the cycle after the sampling edge.
  task automatic applyStimulus(input int base, input int count, input bit wrBusy);
    rd_base_i  = AW'(base);
    rd_count_i = (AW+1)'(count);
    wr_busy_i  = wrBusy;
    start_i    = 1'b1;
    @(posedge clk);
    #1;
    acceptCyc = cyc - 1;
    start_i   = 1'b0;
    wr_busy_i = 1'b0;
  endtask

  task automatic openWindow(input int base, input int count);
    winBase  = base;
    winCount = count;
    issueCnt = 0;
    popCnt   = 0;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_rden"}, 32'(rden_o), 32'd0);
    checkOutput({tag, "_raddr"}, 32'(raddr_o), 32'd0);
    checkOutput({tag, "_valid"}, 32'(out_valid_o), 32'd0);
    checkOutput({tag, "_last"}, 32'(out_last_o), 32'd0);
    checkOutput({tag, "_data"}, 32'(out_data_o), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy_o), 32'd0);
    checkOutput({tag, "_done"}, 32'(done_o), 32'd0);
    checkOutput({tag, "_start_err"}, 32'(start_err_o), 32'd0);
  endtask

  // Run one window to completion. injectAt >= 0 pulses an extra start that
  // many cycles in; checkTiming enables the full-throughput timing checks.
  task automatic runWindow(input int base, input int count, input bit rdyRand,
                           input int injectAt, input bit checkTiming);
    int d0;
    int n;
    readyRandom = rdyRand;
    openWindow(base, count);
    d0 = doneCount;
    applyStimulus(base, count, 1'b0);
    checkOutput("busy_after_start", 32'(busy_o), 32'd1);
    n = 0;
    while (doneCount == d0 && n < count * 8 + 50) begin
      if (n == injectAt) begin
        rd_base_i  = AW'($urandom_range(0, NWORDS - 1));
        rd_count_i = (AW+1)'(7);
        start_i    = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        checkOutput("busy_start_err", 32'(start_err_o), 32'd1);
        checkOutput("busy_kept", 32'(busy_o), 32'd1);
      end else begin
        @(posedge clk);
        #1;
      end
      n++;
    end
    readyRandom = 1'b0;
    checkOutput("done_seen", 32'(doneCount - d0), 32'd1);
    checkOutput("words_issued", 32'(issueCnt), 32'(count));
    checkOutput("words_popped", 32'(popCnt), 32'(count));
    checkOutput("done_after_last", 32'(doneCyc), 32'(lastHsCyc + 1));
    checkOutput("busy_cleared", 32'(busy_o), 32'd0);
    checkOutput("done_one_cycle", 32'(done_o), 32'd0);
    if (checkTiming) begin
      checkOutput("first_rden", 32'(firstRdenCyc), 32'(acceptCyc + 1));
      checkOutput("last_rden", 32'(lastRdenCyc), 32'(acceptCyc + count));
      checkOutput("first_valid", 32'(firstValidCyc), 32'(acceptCyc + 2 + RD_LAT));
      checkOutput("done_time", 32'(doneCyc), 32'(acceptCyc + 2 + RD_LAT + count));
    end
  endtask

  initial begin
    int d0;
    int n;
    for (int i = 0; i < NWORDS; i++) mem[i] = DW'($urandom);

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkResetValues("reset");
    reset = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] basic window");
    runWindow(16, 4, 1'b0, -1, 1'b1);

    $display("[TB] wrapping window");
    runWindow(1022, 4, 1'b0, -1, 1'b1);

    $display("[TB] backpressure window");
    runWindow(int'($urandom_range(0, NWORDS - 1)), 16, 1'b1, -1, 1'b0);

    $display("[TB] start while busy");
    runWindow(100, 20, 1'b1, 3, 1'b0);

    $display("[TB] full 1024-word window");
    runWindow(341, 1024, 1'b0, -1, 1'b1);

    $display("[TB] single word at top address");
    runWindow(1023, 1, 1'b0, -1, 1'b1);

    $display("[TB] zero-length window");
    openWindow(5, 0);
    d0 = doneCount;
    applyStimulus(5, 0, 1'b0);
    checkOutput("zero_done", 32'(done_o), 32'd1);
    repeat (RD_LAT + 4) @(posedge clk);
    #1;
    checkOutput("zero_done_count", 32'(doneCount - d0), 32'd1);
    checkOutput("zero_no_read", 32'(issueCnt), 32'd0);

    $display("[TB] start rejected by wr_busy");
    applyStimulus(7, 5, 1'b1);
    checkOutput("wrbusy_start_err", 32'(start_err_o), 32'd1);
    checkOutput("wrbusy_busy", 32'(busy_o), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("wrbusy_err_pulse", 32'(start_err_o), 32'd0);
    repeat (RD_LAT + 3) @(posedge clk);
    #1;
    checkOutput("wrbusy_no_read", 32'(issueCnt), 32'd0);

    $display("[TB] reset mid-window");
    openWindow(200, 20);
    d0 = doneCount;
    applyStimulus(200, 20, 1'b0);
    n = 0;
    while (popCnt < 5 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("midreset_reached", 32'(popCnt >= 5), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    openWindow(0, 0);
    checkResetValues("midreset");
    reset = 1'b0;
    repeat (RD_LAT + 6) @(posedge clk);
    #1;
    checkOutput("midreset_no_done", 32'(doneCount - d0), 32'd0);
    runWindow(500, 9, 1'b0, -1, 1'b1);

    $display("[TB] random windows");
    for (int k = 0; k < 6; k++) begin
      runWindow(int'($urandom_range(0, NWORDS - 1)), int'($urandom_range(1, 40)),
                1'($urandom_range(0, 1)), -1, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spy_readout.md
Name: spy_readout

Overview:
Read-side controller for the 1024-word spy capture memory. On a start request it reads a programmable window of addresses from the memory's read port and streams the words out over a valid/ready interface, with end-of-window marking. It sits between the spy memory and the register/readout link, opposite the capture-side write controller. Backpressure is absorbed by a small credit-controlled output FIFO.

Parameters:
AW, 10, memory address width (depth 2^AW)
DW, 16, memory/output data width
RD_LAT, 2, memory read latency in cycles from rden to rdata valid; legal 1..3
FIFO_DEPTH, RD_LAT+2, output FIFO entries; must be >= RD_LAT+1

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle readout request
rd_base  in  AW  first address of window, sampled on accepted start
rd_count  in  AW+1  words to read (0..2^AW), sampled on accepted start
wr_busy  in  1  capture side writing (writer wren); blocks start
rden  out  1  memory read enable
raddr  out  AW  memory read address
rdata  in  DW  memory read data, valid RD_LAT cycles after rden
out_data  out  DW  streamed word
out_valid  out  1  out_data valid
out_ready  in  1  sink accepts word when out_valid && out_ready
out_last  out  1  marks final word of window, qualified by out_valid
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at window completion
start_err  out  1  one-cycle pulse when start is rejected

Behaviour:
- Reset values: rden=0, raddr=0, out_valid=0, out_last=0, out_data=0, busy=0, done=0, start_err=0. Reset clears the FIFO, in-flight tracking and state; reset mid-window aborts it with no done pulse.
- FSM: IDLE, READ, DRAIN.
- IDLE: start && !wr_busy -> latch rd_base/rd_count, busy=1. If rd_count==0, go to IDLE and pulse done next cycle; else go to READ. start && wr_busy -> start_err pulse, stay IDLE.
- start while busy: ignored, start_err pulse.
- READ: issue rden=1 in a cycle only if inflight + fifo_count < FIFO_DEPTH (inflight = reads issued whose data has not yet been pushed). raddr starts at rd_base and increments by 1 per issued read; wraps modulo 2^AW (0x3FF -> 0x000). Leave READ for DRAIN on the cycle the rd_count-th read issues.
- rden is registered: start accepted at edge T -> first rden/raddr=rd_base in cycle T+1.
- Data capture: rdata is pushed into the FIFO at the edge ending cycle (issue cycle + RD_LAT), via an RD_LAT-deep valid shift register. With out_ready=1, the first out_valid occurs in cycle T+2+RD_LAT, then one word per cycle (full throughput).
- The FIFO never overflows by construction (credit check); an overflow is an assertion failure.
- out_data/out_valid come from the FIFO head; stable while out_valid && !out_ready.
- out_last = out_valid && (head word is word rd_count of window); tracked by a pop counter of width AW+1.
- DRAIN: after the handshake of the last word -> IDLE, busy=0, done=1 in the following cycle.
- Simultaneous push and pop on the same edge keeps fifo_count unchanged; legal at full and at empty.
- Window of 1024 words from any base reads every address exactly once.

Decomposition:
- Package spy_pkg: SPY_AW=10, SPY_DW=16, readout state enum (IDLE/READ/DRAIN), shared with the capture-side controller.
- Sub-module spy_readout_fifo: synchronous FIFO (DEPTH, DW parameters) with push, pop, head data, count, full and empty. Show-ahead head, no read latency.

Test Plan:
- Basic: rd_base=0x010, rd_count=4, out_ready=1 -> rden cycles T+1..T+4 at 0x010..0x013; 4 words out in order; out_last on 4th; done one cycle after.
- Wrap: rd_base=0x3FE, rd_count=4 -> raddr 0x3FE,0x3FF,0x000,0x001; data matches memory model.
- Backpressure: rd_count=16, out_ready toggled randomly, 8 stall cycles -> no loss/duplication; rden paused when credits exhausted; out_data stable while stalled.
- Full window: rd_base=0x155, rd_count=1024 -> every address read once; out_last on word 1024.
- Zero/reject: rd_count=0 -> done next cycle, no out_valid; start with wr_busy=1 -> start_err pulse, busy stays 0; start during a busy window -> start_err, window unaffected.
- Reset mid-window: reset after 5 of 20 words -> all outputs at reset values next cycle, no done; a new start then runs a clean window.
